// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types (CDB slice)
// Shared types and constants for the common-data-bus writeback path.
//   NUM_CDB_REQ   : number of writeback requesters on the CDB
//   CDB_ALU/MUL/DIV : requester indices
//   cdb_req_t     : one writeback result as handed to the CDB arbiter
//   cdb_next_ptr  : round-robin pointer successor with wrap
// ---------------------------------------------------------------------------
package rv32i_types;

  localparam int NUM_CDB_REQ   = 3;
  localparam int CDB_ALU       = 0;
  localparam int CDB_MUL       = 1;
  localparam int CDB_DIV       = 2;

  localparam int CDB_ROB_IDX_W = 5;
  localparam int CDB_DATA_W    = 32;

  typedef struct packed {
    logic                     valid;
    logic [4:0]               rd_addr;
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
    logic [CDB_DATA_W-1:0]    data;
  } cdb_req_t;

  // Successor of a granted index: one above the winner, wrapping to 0.
  function automatic int cdb_next_ptr(input int w, input int n);
    return (w == n - 1) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches req upward starting at ptr,
// wrapping past the top, and returns the first set bit.
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    index with highest priority this cycle
//   grant  out NUM_REQ  one-hot grant, zero when req is zero
//   winner out IDX_W    index of the granted bit (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] masked;
  logic                 found;

  // Requests are laid out twice side by side; masking off everything below
  // ptr leaves the upper copy to supply the wrapped-around candidates, so a
  // single LSB-first scan gives the round-robin winner.
  // NOTE: always_comb uses blocking '=' and gives every output a default up
  // front; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    req_dbl = {req, req};
    masked  = '0;
    grant   = '0;
    winner  = '0;
    found   = 1'b0;
    for (int b = 0; b < 2 * NUM_REQ; b++) begin
      masked[b] = req_dbl[b] && (b >= int'(ptr));
    end
    for (int b = 0; b < 2 * NUM_REQ; b++) begin
      if (masked[b] && !found) begin
        found                 = 1'b1;
        grant[b % NUM_REQ]    = 1'b1;
        winner                = IDX_W'(b % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the common data bus among NUM_REQ writeback requesters. Each
// requester owns a one-entry holding slot filled by a valid/ready handshake;
// every cycle one occupied slot is granted and broadcast to the ROB and RS.
//
// Build option: CDB_AGE_PRIORITY_EN
//   defined   : grant the oldest slot, age = rob_idx - rob_head_addr (mod
//               2^ROB_IDX_W), ties to the lowest index
//   undefined : round-robin from rr_ptr; rob_head_addr is ignored
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_valid      per-requester result valid
//   req_ready      per-requester slot can accept
//   req_rd_addr    flattened rd, requester i at [5i+4:5i]
//   req_rob_idx    flattened ROB index
//   req_data       flattened result data
//   flush          pipeline flush: no broadcast, slots cleared, inputs dropped
//   rob_head_addr  ROB head (age-priority build only)
//   cdb_valid, cdb_rd_addr, cdb_rob_idx, cdb_data, cdb_src  broadcast
// ---------------------------------------------------------------------------
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ   = NUM_CDB_REQ,
  parameter int ROB_IDX_W = CDB_ROB_IDX_W,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*5-1:0]           req_rd_addr,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  input  logic                           flush,
  input  logic [ROB_IDX_W-1:0]           rob_head_addr,
  output logic                           cdb_valid,
  output logic [4:0]                     cdb_rd_addr,
  output logic [ROB_IDX_W-1:0]           cdb_rob_idx,
  output logic [DATA_W-1:0]              cdb_data,
  output logic [SRC_W-1:0]               cdb_src
);

  logic [NUM_REQ-1:0]   occ_q, occ_d;
  logic [4:0]           rd_q   [NUM_REQ];
  logic [4:0]           rd_d   [NUM_REQ];
  logic [ROB_IDX_W-1:0] rob_q  [NUM_REQ];
  logic [ROB_IDX_W-1:0] rob_d  [NUM_REQ];
  logic [DATA_W-1:0]    data_q [NUM_REQ];
  logic [DATA_W-1:0]    data_d [NUM_REQ];

  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   capture;
  logic [SRC_W-1:0]     win_idx;

  // A slot frees up in the same cycle it is granted, so the producer can
  // refill it at that edge and sustain one result per cycle.
  assign req_ready = {NUM_REQ{!rst && !flush}} & (~occ_q | grant);
  assign capture   = req_valid & req_ready;

`ifdef CDB_AGE_PRIORITY_EN
  logic [ROB_IDX_W-1:0] age;
  logic [ROB_IDX_W-1:0] best_age;
  logic                 found;

  // Ascending scan with strict '<' keeps the lowest index on equal ages.
  always_comb begin
    grant    = '0;
    win_idx  = '0;
    age      = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age = rob_q[i] - rob_head_addr;
      if (occ_q[i] && (!found || age < best_age)) begin
        found    = 1'b1;
        best_age = age;
        win_idx  = SRC_W'(i);
      end
    end
    if (found) grant[win_idx] = 1'b1;
  end
`else
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             unused_rob_head;

  assign unused_rob_head = ^rob_head_addr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_rr_arbiter (
    .req    (occ_q),
    .ptr    (rr_ptr_q),
    .grant  (grant),
    .winner (win_idx)
  );

  // A flushed grant never reached the bus, so it does not advance priority.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant && !flush) begin
      rr_ptr_d = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Capture wins over the grant-clear so a same-edge refill keeps occ set;
  // flush overrides both.
  always_comb begin
    occ_d = occ_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_d[i]   = rd_q[i];
      rob_d[i]  = rob_q[i];
      data_d[i] = data_q[i];
      if (grant[i]) occ_d[i] = 1'b0;
      if (capture[i]) begin
        occ_d[i]  = 1'b1;
        rd_d[i]   = req_rd_addr[5*i +: 5];
        rob_d[i]  = req_rob_idx[ROB_IDX_W*i +: ROB_IDX_W];
        data_d[i] = req_data[DATA_W*i +: DATA_W];
      end
    end
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  // NOTE: slot payloads carry no reset; occ_q alone says whether a slot
  // holds anything, and the bus outputs are zeroed whenever nothing is granted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_q[i]   <= rd_d[i];
      rob_q[i]  <= rob_d[i];
      data_q[i] <= data_d[i];
    end
  end

  always_comb begin
    cdb_valid   = |grant && !flush;
    cdb_rd_addr = '0;
    cdb_rob_idx = '0;
    cdb_data    = '0;
    cdb_src     = '0;
    if (|grant) begin
      cdb_rd_addr = rd_q[win_idx];
      cdb_rob_idx = rob_q[win_idx];
      cdb_data    = data_q[win_idx];
      cdb_src     = win_idx;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run against a slot/priority reference model. Honours CDB_AGE_PRIORITY_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_rd_addr;
  logic [N*RW-1:0] req_rob_idx;
  logic [N*DW-1:0] req_data;
  logic            flush;
  logic [RW-1:0]   rob_head_addr;
  logic            cdb_valid;
  logic [4:0]      cdb_rd_addr;
  logic [RW-1:0]   cdb_rob_idx;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rd_addr   (req_rd_addr),
    .req_rob_idx   (req_rob_idx),
    .req_data      (req_data),
    .flush         (flush),
    .rob_head_addr (rob_head_addr),
    .cdb_valid     (cdb_valid),
    .cdb_rd_addr   (cdb_rd_addr),
    .cdb_rob_idx   (cdb_rob_idx),
    .cdb_data      (cdb_data),
    .cdb_src       (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] rd,
                       input logic [RW-1:0] rob, input logic [DW-1:0] d);
    req_valid[i]             = v;
    req_rd_addr[5*i +: 5]    = rd;
    req_rob_idx[RW*i +: RW]  = rob;
    req_data[DW*i +: DW]     = d;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = '0;
    flush         = 1'b0;
    rob_head_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst           = 1'b1;
    flush         = 1'b0;
    rob_head_addr = '0;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 5'(i + 1), RW'(i), DW'(i));
    tick();
    tick();
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
    n_checks++; if ({cdb_rd_addr, cdb_rob_idx, cdb_data, cdb_src} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got rd=%0d rob=%0d data=%h src=%0d want all 0", cdb_rd_addr, cdb_rob_idx, cdb_data, cdb_src);
    end
    req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 1'b1, 5'd5, 5'd3, 32'hDEAD_BEEF);
    #1;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_valid: got %b want 0", cdb_valid); end
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_c1_valid: got %b want 1", cdb_valid); end
    n_checks++; if ({cdb_rd_addr, cdb_rob_idx, cdb_data, cdb_src} !== {5'd5, 5'd3, 32'hDEAD_BEEF, 2'd0}) begin
      n_fail++; $display("FAIL single_c1_bus: got rd=%0d rob=%0d data=%h src=%0d want 5 3 deadbeef 0", cdb_rd_addr, cdb_rob_idx, cdb_data, cdb_src);
    end
    tick();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_c2_valid: got %b want 0", cdb_valid); end
  endtask

  // Contention with ALU re-offered every cycle; ALU's own backpressure while
  // MUL and DIV are served.
  task automatic test_contention();
    logic [1:0]  exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] exp_dat [5] = '{32'hA000_0000, 32'hB000_0001, 32'hC000_0002, 32'hA000_0001, 32'hA000_0002};
    logic        exp_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    drive(0, 1'b1, 5'd1, 5'd10, 32'hA000_0000);
    drive(1, 1'b1, 5'd2, 5'd11, 32'hB000_0001);
    drive(2, 1'b1, 5'd3, 5'd12, 32'hC000_0002);
    tick();
    drive(1, 1'b0, 5'd0, 5'd0, 32'h0);
    drive(2, 1'b0, 5'd0, 5'd0, 32'h0);
    drive(0, 1'b1, 5'd4, 5'd13, 32'hA000_0001);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (cdb_valid !== 1'b1 || cdb_src !== exp_src[c] || cdb_data !== exp_dat[c]) begin
        n_fail++; $display("FAIL contention_c%0d: got v=%b src=%0d data=%h want v=1 src=%0d data=%h", c + 1, cdb_valid, cdb_src, cdb_data, exp_src[c], exp_dat[c]);
      end
      n_checks++; if (req_ready[0] !== exp_rdy[c]) begin
        n_fail++; $display("FAIL contention_rdy_c%0d: got %b want %b", c + 1, req_ready[0], exp_rdy[c]);
      end
      // The producer swaps payload only after a handshake.
      if (c == 0) begin tick(); drive(0, 1'b1, 5'd5, 5'd14, 32'hA000_0002); end
      else if (c == 3) begin tick(); req_valid = '0; end
      else tick();
    end
    #1;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL contention_drain: got %b want 0", cdb_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, 1'b1, 5'd1, 5'd1, 32'h1111_0000);
    drive(1, 1'b1, 5'd2, 5'd2, 32'h2222_0001);
    tick();
    drive(0, 1'b0, 5'd0, 5'd0, 32'h0);
    drive(1, 1'b1, 5'd6, 5'd6, 32'h2222_0002);
    #1;
    n_checks++; if (req_ready[1] !== 1'b0 || cdb_src !== 2'd0) begin
      n_fail++; $display("FAIL bp_blocked: got rdy1=%b src=%0d want 0 0", req_ready[1], cdb_src);
    end
    tick();
    n_checks++; if (req_ready[1] !== 1'b1 || cdb_src !== 2'd1 || cdb_data !== 32'h2222_0001) begin
      n_fail++; $display("FAIL bp_grant: got rdy1=%b src=%0d data=%h want 1 1 22220001", req_ready[1], cdb_src, cdb_data);
    end
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_data !== 32'h2222_0002) begin
      n_fail++; $display("FAIL bp_held: got v=%b src=%0d data=%h want 1 1 22220002", cdb_valid, cdb_src, cdb_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 1'b1, 5'd1, 5'd1, 32'h0000_00A0);
    drive(2, 1'b1, 5'd3, 5'd3, 32'h0000_00C0);
    tick();
    req_valid = '0;
    tick();                       // ALU granted, priority moves to MUL
    flush = 1'b1;
    drive(1, 1'b1, 5'd2, 5'd2, 32'h0000_00B0);
    #1;
    n_checks++; if (cdb_valid !== 1'b0 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL flush_cycle: got v=%b rdy=%b want 0 000", cdb_valid, req_ready);
    end
    tick();
    flush = 1'b0;
    req_valid = '0;
    #1;
    n_checks++; if (cdb_valid !== 1'b0 || req_ready !== 3'b111) begin
      n_fail++; $display("FAIL flush_after: got v=%b rdy=%b want 0 111", cdb_valid, req_ready);
    end
    drive(0, 1'b1, 5'd7, 5'd7, 32'h0000_00A7);
    drive(1, 1'b1, 5'd8, 5'd8, 32'h0000_00B8);
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1) begin
      n_fail++; $display("FAIL flush_ptr_kept: got v=%b src=%0d want 1 1", cdb_valid, cdb_src);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 1'b1, 5'd2, 5'd2, 32'h0);
    tick();
    req_valid = '0;
    tick();                       // MUL granted, priority now at DIV
    for (int i = 0; i < N; i++) drive(i, 1'b1, 5'(i), 5'(i), 32'(i));
    tick();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (cdb_src !== SW'((c + 2) % 3) || cdb_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_c%0d: got v=%b src=%0d want 1 %0d", c, cdb_valid, cdb_src, (c + 2) % 3);
      end
      tick();
    end
  endtask

  task automatic test_age();
    do_reset();
    rob_head_addr = 5'd30;
    drive(0, 1'b1, 5'd1, 5'd1, 32'hA);
    drive(1, 1'b1, 5'd2, 5'd31, 32'hB);
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_src !== 2'd1 || cdb_rob_idx !== 5'd31) begin
      n_fail++; $display("FAIL age_oldest: got src=%0d rob=%0d want 1 31", cdb_src, cdb_rob_idx);
    end
    tick();
    n_checks++; if (cdb_src !== 2'd0 || cdb_valid !== 1'b1) begin
      n_fail++; $display("FAIL age_second: got v=%b src=%0d want 1 0", cdb_valid, cdb_src);
    end
    tick();
    rob_head_addr = 5'd0;
    drive(0, 1'b1, 5'd1, 5'd5, 32'hA);
    drive(2, 1'b1, 5'd3, 5'd5, 32'hC);
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_src !== 2'd0) begin n_fail++; $display("FAIL age_tie: got src=%0d want 0", cdb_src); end
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 1'b1, 5'd1, 5'd1, 32'h5555_0000);
    drive(1, 1'b1, 5'd2, 5'd2, 32'h5555_0001);
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b want 1", cdb_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (cdb_valid !== 1'b0 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL arst_immediate: got v=%b rdy=%b want 0 000", cdb_valid, req_ready);
    end
    #1 rst = 1'b0;
    tick();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_lost1: got %b want 0", cdb_valid); end
    tick();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_lost2: got %b want 0", cdb_valid); end
    drive(2, 1'b1, 5'd9, 5'd9, 32'h5555_0009);
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h5555_0009) begin
      n_fail++; $display("FAIL arst_new: got v=%b data=%h want 1 55550009", cdb_valid, cdb_data);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: per-slot contents plus the arbitration rule.
  logic          m_occ  [N];
  logic [4:0]    m_rd   [N];
  logic [RW-1:0] m_rob  [N];
  logic [DW-1:0] m_data [N];
  int            m_ptr;
  int            m_wait [N];

  function automatic int model_grant();
    int g = -1;
`ifdef CDB_AGE_PRIORITY_EN
    int best = 1 << RW;
    for (int i = 0; i < N; i++) begin
      int age = (int'(m_rob[i]) - int'(rob_head_addr) + (1 << RW)) % (1 << RW);
      if (m_occ[i] && age < best) begin
        best = age;
        g    = i;
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (m_occ[idx] && g < 0) g = idx;
    end
`endif
    return g;
  endfunction

  task automatic test_random();
    logic          p_v    [N];
    logic [4:0]    p_rd   [N];
    logic [RW-1:0] p_rob  [N];
    logic [DW-1:0] p_data [N];
    logic [N-1:0]  exp_ready;
    int            g;
    logic          exp_valid;
    do_reset();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_occ[i] = 1'b0; m_wait[i] = 0; p_v[i] = 1'b0;
      m_rd[i] = '0; m_rob[i] = '0; m_data[i] = '0;
      p_rd[i] = '0; p_rob[i] = '0; p_data[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_v[i] && $urandom_range(0, 99) < 60) begin
          p_v[i]    = 1'b1;
          p_rd[i]   = 5'($urandom);
          p_rob[i]  = RW'($urandom);
          p_data[i] = $urandom;
        end
        drive(i, p_v[i], p_rd[i], p_rob[i], p_data[i]);
      end
      flush         = ($urandom_range(0, 99) < 4);
      rob_head_addr = RW'($urandom);
      #1;
      g         = model_grant();
      exp_valid = (g >= 0) && !flush;
      for (int i = 0; i < N; i++) exp_ready[i] = !flush && (!m_occ[i] || g == i);
      n_checks++; if (req_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, req_ready, exp_ready);
      end
      n_checks++; if (cdb_valid !== exp_valid) begin
        n_fail++; $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, cdb_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (cdb_src !== SW'(g) || cdb_rd_addr !== m_rd[g] || cdb_rob_idx !== m_rob[g] || cdb_data !== m_data[g]) begin
          n_fail++; $display("FAIL rand_bus cyc%0d: got src=%0d rd=%0d rob=%0d data=%h want src=%0d rd=%0d rob=%0d data=%h",
                             cyc, cdb_src, cdb_rd_addr, cdb_rob_idx, cdb_data, g, m_rd[g], m_rob[g], m_data[g]);
        end
      end
`ifndef CDB_AGE_PRIORITY_EN
      // Starvation bound observed on the bus itself.
      for (int i = 0; i < N; i++) begin
        if (flush || !m_occ[i] || (cdb_valid && cdb_src == SW'(i))) m_wait[i] = 0;
        else begin
          m_wait[i]++;
          n_checks++; if (m_wait[i] > N - 1) begin
            n_fail++; $display("FAIL rand_starve cyc%0d slot%0d: waited %0d want <= %0d", cyc, i, m_wait[i], N - 1);
          end
        end
      end
`endif
      if (flush) begin
        for (int i = 0; i < N; i++) begin m_occ[i] = 1'b0; p_v[i] = 1'b0; end
      end else begin
        if (g >= 0) begin
          m_occ[g] = 1'b0;
`ifndef CDB_AGE_PRIORITY_EN
          m_ptr = (g == N - 1) ? 0 : g + 1;
`endif
        end
        for (int i = 0; i < N; i++) begin
          if (p_v[i] && exp_ready[i]) begin
            m_occ[i]  = 1'b1;
            m_rd[i]   = p_rd[i];
            m_rob[i]  = p_rob[i];
            m_data[i] = p_data[i];
            p_v[i]    = 1'b0;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    flush     = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    req_valid     = '0;
    req_rd_addr   = '0;
    req_rob_idx   = '0;
    req_data      = '0;
    rob_head_addr = '0;
    test_reset();
    test_single();
`ifdef CDB_AGE_PRIORITY_EN
    test_age();
`else
    test_contention();
    test_backpressure();
    test_flush();
    test_wrap();
`endif
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ functional-unit writeback requesters, e.g. ALU, MUL and DIV.
- Each requester hands off one result per valid/ready handshake into a private one-entry holding slot.
- Each cycle the arbiter grants one occupied slot and broadcasts its rd_addr, rob_idx and data to the ROB and reservation stations.
- Sits between the execute units and the ROB/RS CDB inputs.

Parameters:
NUM_REQ, 3, number of requesters (index 0=ALU, 1=MUL, 2=DIV)
ROB_IDX_W, 5, ROB index width (32-entry ROB)
DATA_W, 32, result width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester result valid
req_ready  out  NUM_REQ  per-requester slot can accept
req_rd_addr  in  NUM_REQ*5  flattened rd, requester i at [5i+4:5i]
req_rob_idx  in  NUM_REQ*ROB_IDX_W  flattened ROB index
req_data  in  NUM_REQ*DATA_W  flattened result
flush  in  1  pipeline flush (mispredict)
rob_head_addr  in  ROB_IDX_W  current ROB head; used only with CDB_AGE_PRIORITY_EN
cdb_valid  out  1  broadcast valid
cdb_rd_addr  out  5  broadcast rd
cdb_rob_idx  out  ROB_IDX_W  broadcast ROB index
cdb_data  out  DATA_W  broadcast data
cdb_src  out  $clog2(NUM_REQ)  index of granted requester

Behaviour:
- Reset:
  - All slots empty; rr_ptr=0.
  - cdb_valid=0; cdb_rd_addr, cdb_rob_idx, cdb_data and cdb_src = 0.
  - req_ready=0 while rst is high.
- Slot i holds {occ, rd_addr, rob_idx, data}.
  - req_ready[i] = !rst && !flush && (!occ[i] || grant[i]).
  - Capture at clk edge when req_valid[i] && req_ready[i]; occ[i]<=1.
- Grant, combinational from slot flops:
  - Round-robin over occ[] starting at rr_ptr, searching upward with wrap.
  - grant is one-hot or zero.
  - cdb_* is driven from the winning slot. cdb_valid = |grant && !flush.
- Latency:
  - A result accepted at edge N is broadcast no earlier than cycle N+1.
  - A slot can be refilled at the same edge it is granted (full throughput: 1 result/cycle/requester if uncontended).
- Pointer: on grant of index w, rr_ptr <= (w==NUM_REQ-1) ? 0 : w+1. The pointer does not move when there is no grant.
- Starvation bound: an occupied slot is granted within NUM_REQ cycles.
- Simultaneous grant+capture on the same slot: the new result overwrites the slot and occ stays 1.
- Flush:
  - cdb_valid=0 that cycle; all occ cleared at the edge.
  - Inputs presented during flush are dropped (ready=0).
  - rr_ptr is preserved.
- rd_addr==0 results are still broadcast; x0 filtering is the ROB's job.
- Async reset asserted mid-operation:
  - Immediately clears outputs and slots.
  - Held results are lost, with no partial broadcast.

Optional Feature:
CDB_AGE_PRIORITY_EN
- Defined:
  - Grant the occupied slot with the smallest age = (rob_idx - rob_head_addr) mod 2^ROB_IDX_W, i.e. the oldest instruction.
  - Ties go to the lowest index. rr_ptr is unused and held at 0.
- Undefined: round-robin as above; rob_head_addr is ignored.

Decomposition:
- Package rv32i_types gains:
  - cdb_req_t {valid, rd_addr[4:0], rob_idx, data}
  - localparam NUM_CDB_REQ=3
  - localparam CDB_ALU=0, CDB_MUL=1, CDB_DIV=2
- Sub-module rr_arbiter(NUM_REQ): req vector + ptr in, one-hot grant + winner index out, combinational, double-width mask method.
- The age comparator stays inline under the ifdef.

Test Plan:
- Single: ALU valid, rd=5, rob=3, data=0xDEAD_BEEF at edge 0 -> cycle 1: cdb_valid=1, rd=5, rob=3, data=0xDEADBEEF, src=0; cycle 2: cdb_valid=0.
- Contention: ALU, MUL and DIV all valid at edge 0, rr_ptr=0 -> broadcasts src 0, 1, 2 in cycles 1, 2, 3. ALU re-offered every cycle -> order 0, 1, 2, 0 and no requester waits more than 3 cycles.
- Backpressure: MUL slot occupied and not granted -> req_ready[1]=0, the new MUL result is held by the producer and not lost; it is accepted the cycle the slot is granted.
- Flush: two slots occupied, flush=1 -> cdb_valid=0 that cycle, all req_ready=0, next cycle slots empty and no stale broadcast.
- Wrap: rr_ptr=2, DIV granted -> rr_ptr=0. With CDB_AGE_PRIORITY_EN, head=30, ALU rob=1, MUL rob=31 -> MUL granted first (age 1 vs 3).
- Async reset pulse mid-burst (between edges) -> cdb_valid falls immediately; after release, first broadcast needs a new handshake.
